victim_control: RTL and testbench
=================================

# victim_control

Sequencing controller for the 16-entry fully-associative victim buffer (`victim_datapath`), placed between L2 and physical memory. It accepts L2 eviction writes and L2 miss reads, performs the 16-way tag match, and chooses the replacement entry. It writes back dirty displaced entries and forwards read misses to pmem. It also clears the datapath's unreset valid array after reset.

## Interface
Parameters:
- `ENTRIES`, 16: number of victim entries. Fixed at 16; the datapath mux select is 5 bits.

Ports:
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `mem_read`  in  1  L2 miss read; held until `mem_resp`
- `mem_write`  in  1  L2 eviction write; held until `mem_resp`
- `mem_dirty`  in  1  evicted line is dirty; qualifies `mem_write`
- `mem_address`  in  16  line address; bits [15:4] are the tag
- `mem_resp`  out  1  one-cycle completion pulse to L2
- `pmem_read`, `pmem_write`  out  1  physical memory request; held until `pmem_resp`
- `pmem_resp`  in  1  physical memory completion
- `tag_data_line`  in  12 x [15:0]  per-entry tags from the datapath (unpacked array)
- `valid_out`, `dirty_out`  in  1 x [15:0]  per-entry status bits
- `mem_rdata_mux_sel`, `pmem_address_mux_sel`, `pmem_wdata_mux_sel`  out  5  selects: 0 = pass-through, k+1 = entry k
- `write`  out  1  datapath array write strobe
- `idx`  out  4  entry written
- `valid_in`, `dirty_in`  out  1  status bits written

## Operation
- States: INIT, IDLE, RD_HIT, RD_MISS, EVICT_WB, INSERT.
- **Hit logic (combinational):**
  - `hit[k] = valid_out[k] && tag_data_line[k] == mem_address[15:4]`.
  - `hit_idx` is the lowest set k.
  - `free_idx` is the lowest invalid entry.
- **INIT:**
  - Entered on reset.
  - Counter sweeps 0..15 with `write=1`, `idx=cnt`, `valid_in=0`, `dirty_in=0`.
  - Goes to IDLE after entry 15.
  - Requests are ignored; `mem_resp` stays 0.
- **IDLE:**
  - `mem_write` has priority over `mem_read` when both are asserted.
  - Write with any hit: target = `hit_idx`, go to INSERT.
  - Write with no hit and any invalid entry: target = `free_idx`, go to INSERT.
  - Write with no hit and buffer full: target = `fifo_ptr`. If that entry is dirty go to EVICT_WB, otherwise INSERT.
  - Read with a hit: go to RD_HIT.
  - Read with no hit: go to RD_MISS.
- **RD_HIT:**
  - `mem_rdata_mux_sel = hit_idx+1` and `mem_resp=1`, then IDLE.
  - The entry is unchanged; the buffer is non-exclusive.
- **RD_MISS:**
  - `pmem_read=1`, `pmem_address_mux_sel=0`, `mem_rdata_mux_sel=0`.
  - On `pmem_resp`, assert `mem_resp` in the same cycle, then IDLE.
- **EVICT_WB:**
  - `pmem_write=1`, address and wdata selects = target+1.
  - On `pmem_resp`, go to INSERT.
- **INSERT:**
  - `write=1`, `idx=target`, `valid_in=1`, `dirty_in=mem_dirty`, `mem_resp=1`, then IDLE.
  - A write hit overwrites the line with the new data; it is dirty if either the old or the new copy was dirty (`dirty_in = mem_dirty | dirty_out[hit_idx]`).
- **`fifo_ptr`:**
  - 4-bit register.
  - Increments, wrapping 15→0, only after an INSERT that used it.
  - Unchanged on hit or free-slot inserts.
- Target index is latched in IDLE; it is not recomputed in later states.

## Timing
- **Reset values:**
  - All outputs 0 except the INIT sweep drive: `write=1`, `idx=0`.
  - `fifo_ptr=0`, state INIT.
- **Reset mid-operation:**
  - Any pmem request is dropped the next cycle.
  - `mem_resp` is never issued for the aborted request.
  - INIT reruns in full.
- **Latency:**
  - INIT is 16 cycles.
  - Read hit: `mem_resp` 1 cycle after the request is sampled in IDLE.
  - Insert without writeback: `mem_resp` 1 cycle after sampling.
  - Read miss: `mem_resp` in the same cycle as `pmem_resp`.
  - Dirty eviction: `mem_resp` 1 cycle after `pmem_resp`.
- **Handshake:**
  - `mem_resp` is a single-cycle pulse.
  - The controller returns to IDLE and samples a new request no earlier than the cycle after `mem_resp`.
  - `pmem_*` stays asserted and selects stay stable until `pmem_resp`.
  - At most one of `pmem_read`/`pmem_write` is asserted at any time.

## Configuration
- `VICTIM_PERF_EN` defined:
  - Adds outputs `perf_hits`, `perf_misses`, `perf_writebacks` (16 bits each).
  - Each is a saturating counter: +1 per RD_HIT entry, per RD_MISS completion, and per EVICT_WB completion respectively.
  - Cleared by reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- **In `lc3b_types`:**
  - `lc3b_victim_idx` (logic [3:0]).
  - `lc3b_victim_sel` (logic [4:0]).
  - `VICTIM_ENTRIES = 16`.
- The state enum is local to the module.
- One sub-module, `victim_tag_match`:
  - 16 tag comparators plus lowest-index priority encoders.
  - Outputs `hit`, `hit_idx`, `any_free`, `free_idx`.

## Test plan
- Reset then idle → `write=1` for 16 cycles with `idx` 0..15 and `valid_in=0`, then `write=0`. A `mem_read` issued during INIT gets no `mem_resp` until it is handled after INIT.
- Write `mem_address=0x1230` with `mem_dirty=1` into an empty buffer → INSERT at `idx=0`, `valid_in=1`, `dirty_in=1`, `mem_resp` 1 cycle after sampling.
- Read `0x1238` after the previous write → RD_HIT, `mem_rdata_mux_sel=1`, `mem_resp` next cycle, no pmem activity.
- Fill 16 entries with dirty lines, then write a new tag → EVICT_WB with `pmem_write=1` and `pmem_address_mux_sel=1` until `pmem_resp`, then INSERT at `idx=0`; `fifo_ptr` becomes 1.
- Read miss `0xBEE0` with `pmem_resp` after 5 cycles → `pmem_read` held 5 cycles, `mem_rdata_mux_sel=0`, `mem_resp` coincident with `pmem_resp`.
- Assert `reset_n=0` during EVICT_WB → `pmem_write` drops next cycle, no `mem_resp`, INIT reruns, `fifo_ptr=0`.

Source files
------------

// File: rtl/victim_control_pkg.sv
// rtl/victim_control_pkg.sv - shared victim buffer types, sizes and select helper
package lc3b_types;
   localparam int VICTIM_ENTRIES = 16;

   typedef logic [3:0]  lc3b_victim_idx;
   typedef logic [4:0]  lc3b_victim_sel;
   typedef logic [11:0] lc3b_victim_tag;

   // Datapath muxes reserve select 0 for pass-through, so entry k is k+1.
   function automatic lc3b_victim_sel victim_sel(input lc3b_victim_idx i);
      return {1'b0, i} + 5'd1;
   endfunction
endpackage

// File: rtl/victim_control_if.sv
// rtl/victim_control_if.sv - L2, pmem and victim datapath signals seen by the controller
interface victim_control_if;
   import lc3b_types::*;

   logic           mem_read;
   logic           mem_write;
   logic           mem_dirty;
   logic [15:0]    mem_address;
   logic           mem_resp;

   logic           pmem_read;
   logic           pmem_write;
   logic           pmem_resp;

   lc3b_victim_tag tag_data_line [VICTIM_ENTRIES];
   logic [15:0]    valid_out;
   logic [15:0]    dirty_out;

   lc3b_victim_sel mem_rdata_mux_sel;
   lc3b_victim_sel pmem_address_mux_sel;
   lc3b_victim_sel pmem_wdata_mux_sel;
   logic           write;
   lc3b_victim_idx idx;
   logic           valid_in;
   logic           dirty_in;

   modport ctrl (
      input  mem_read, mem_write, mem_dirty, mem_address, pmem_resp,
      input  tag_data_line, valid_out, dirty_out,
      output mem_resp, pmem_read, pmem_write,
      output mem_rdata_mux_sel, pmem_address_mux_sel, pmem_wdata_mux_sel,
      output write, idx, valid_in, dirty_in
   );

   modport env (
      output mem_read, mem_write, mem_dirty, mem_address, pmem_resp,
      output tag_data_line, valid_out, dirty_out,
      input  mem_resp, pmem_read, pmem_write,
      input  mem_rdata_mux_sel, pmem_address_mux_sel, pmem_wdata_mux_sel,
      input  write, idx, valid_in, dirty_in
   );
endinterface

// File: rtl/victim_control_tag_match.sv
// rtl/victim_control_tag_match.sv - 16-way tag compare with lowest-index hit and free encoders
module victim_tag_match
   import lc3b_types::*;
(
   input  lc3b_victim_tag             tag_data_line [VICTIM_ENTRIES],
   input  logic [VICTIM_ENTRIES-1:0]  valid_out,
   input  lc3b_victim_tag             tag,
   output logic [VICTIM_ENTRIES-1:0]  hit,
   output lc3b_victim_idx             hit_idx,
   output logic                       any_free,
   output lc3b_victim_idx             free_idx
);
   always_comb begin
      hit      = '0;
      hit_idx  = '0;
      free_idx = '0;
      for (int k = 0; k < VICTIM_ENTRIES; k++) begin
         hit[k] = valid_out[k] && (tag_data_line[k] == tag);
      end
      // Walking downward leaves the lowest matching index as the final value.
      for (int k = VICTIM_ENTRIES - 1; k >= 0; k--) begin
         if (hit[k]) begin
            hit_idx = lc3b_victim_idx'(k);
         end
         if (!valid_out[k]) begin
            free_idx = lc3b_victim_idx'(k);
         end
      end
   end

   assign any_free = ~&valid_out;
endmodule

// File: rtl/victim_control.sv
// rtl/victim_control.sv - victim buffer sequencer: init sweep, lookup, replacement, writeback
// Optional perf counters are built when VICTIM_PERF_EN is defined.
module victim_control
   import lc3b_types::*;
#(
   parameter int ENTRIES = VICTIM_ENTRIES
)
(
   input  logic            clk,
   input  logic            reset_n,
   victim_control_if.ctrl  bus
`ifdef VICTIM_PERF_EN
   ,
   output logic [15:0]     perf_hits,
   output logic [15:0]     perf_misses,
   output logic [15:0]     perf_writebacks
`endif
);
   typedef enum logic [2:0] {
      INIT, IDLE, RD_HIT, RD_MISS, EVICT_WB, INSERT
   } state_t;

   localparam lc3b_victim_idx LAST = lc3b_victim_idx'(ENTRIES - 1);

   state_t                    state;
   lc3b_victim_idx            target;
   lc3b_victim_idx            fifo_ptr;
   logic                      used_fifo;
   logic                      mem_resp_q;

   logic [VICTIM_ENTRIES-1:0] hit;
   lc3b_victim_idx            hit_idx;
   logic                      any_free;
   lc3b_victim_idx            free_idx;

   lc3b_victim_idx            wr_target;
   logic                      wr_fifo;
   logic                      wr_evict;
   logic                      wr_dirty;
   logic                      unused_addr;

   assign unused_addr = ^bus.mem_address[3:0];

   victim_tag_match u_tag_match (
      .tag_data_line (bus.tag_data_line),
      .valid_out     (bus.valid_out),
      .tag           (bus.mem_address[15:4]),
      .hit           (hit),
      .hit_idx       (hit_idx),
      .any_free      (any_free),
      .free_idx      (free_idx)
   );

   always_comb begin
      wr_target = fifo_ptr;
      wr_fifo   = 1'b0;
      wr_dirty  = bus.mem_dirty;
      if (|hit) begin
         wr_target = hit_idx;
         wr_dirty  = bus.mem_dirty | bus.dirty_out[hit_idx];
      end else if (any_free) begin
         wr_target = free_idx;
      end else begin
         wr_fifo = 1'b1;
      end
      wr_evict = wr_fifo && bus.dirty_out[fifo_ptr];
   end

   // Read-miss completion is forwarded combinationally so L2 sees it with pmem_resp.
   assign bus.mem_resp = mem_resp_q | (state == RD_MISS && bus.pmem_resp && reset_n);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state                    <= INIT;
         target                   <= '0;
         fifo_ptr                 <= '0;
         used_fifo                <= 1'b0;
         mem_resp_q               <= 1'b0;
         bus.pmem_read            <= 1'b0;
         bus.pmem_write           <= 1'b0;
         bus.mem_rdata_mux_sel    <= '0;
         bus.pmem_address_mux_sel <= '0;
         bus.pmem_wdata_mux_sel   <= '0;
         bus.write                <= 1'b1;
         bus.idx                  <= '0;
         bus.valid_in             <= 1'b0;
         bus.dirty_in             <= 1'b0;
      end else begin
         mem_resp_q <= 1'b0;
         case (state)
            INIT: begin
               if (bus.idx == LAST) begin
                  bus.write <= 1'b0;
                  bus.idx   <= '0;
                  state     <= IDLE;
               end else begin
                  bus.idx <= bus.idx + 4'd1;
               end
            end

            IDLE: begin
               if (bus.mem_write) begin
                  target    <= wr_target;
                  used_fifo <= wr_fifo;
                  if (wr_evict) begin
                     bus.pmem_write           <= 1'b1;
                     bus.pmem_address_mux_sel <= victim_sel(wr_target);
                     bus.pmem_wdata_mux_sel   <= victim_sel(wr_target);
                     state                    <= EVICT_WB;
                  end else begin
                     bus.write    <= 1'b1;
                     bus.idx      <= wr_target;
                     bus.valid_in <= 1'b1;
                     bus.dirty_in <= wr_dirty;
                     mem_resp_q   <= 1'b1;
                     state        <= INSERT;
                  end
               end else if (bus.mem_read) begin
                  if (|hit) begin
                     bus.mem_rdata_mux_sel <= victim_sel(hit_idx);
                     mem_resp_q            <= 1'b1;
                     state                 <= RD_HIT;
                  end else begin
                     bus.pmem_read            <= 1'b1;
                     bus.pmem_address_mux_sel <= '0;
                     bus.mem_rdata_mux_sel    <= '0;
                     state                    <= RD_MISS;
                  end
               end
            end

            RD_HIT: begin
               bus.mem_rdata_mux_sel <= '0;
               state                 <= IDLE;
            end

            RD_MISS: begin
               if (bus.pmem_resp) begin
                  bus.pmem_read <= 1'b0;
                  state         <= IDLE;
               end
            end

            EVICT_WB: begin
               if (bus.pmem_resp) begin
                  bus.pmem_write           <= 1'b0;
                  bus.pmem_address_mux_sel <= '0;
                  bus.pmem_wdata_mux_sel   <= '0;
                  bus.write                <= 1'b1;
                  bus.idx                  <= target;
                  bus.valid_in             <= 1'b1;
                  bus.dirty_in             <= bus.mem_dirty;
                  mem_resp_q               <= 1'b1;
                  state                    <= INSERT;
               end
            end

            INSERT: begin
               bus.write    <= 1'b0;
               bus.idx      <= '0;
               bus.valid_in <= 1'b0;
               bus.dirty_in <= 1'b0;
               used_fifo    <= 1'b0;
               if (used_fifo) begin
                  fifo_ptr <= fifo_ptr + 4'd1;
               end
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

`ifdef VICTIM_PERF_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         perf_hits       <= '0;
         perf_misses     <= '0;
         perf_writebacks <= '0;
      end else begin
         if (state == RD_HIT && perf_hits != 16'hFFFF) begin
            perf_hits <= perf_hits + 16'd1;
         end
         if (state == RD_MISS && bus.pmem_resp && perf_misses != 16'hFFFF) begin
            perf_misses <= perf_misses + 16'd1;
         end
         if (state == EVICT_WB && bus.pmem_resp && perf_writebacks != 16'hFFFF) begin
            perf_writebacks <= perf_writebacks + 16'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_victim_control.sv
// tb/tb_victim_control.sv - scoreboard bench for victim_control with datapath and pmem models
module tb_victim_control;
   import lc3b_types::*;

   localparam int EV_WR   = 0;
   localparam int EV_RESP = 1;
   localparam int EV_PRD  = 2;
   localparam int EV_PWR  = 3;
   localparam int EV_PEND = 4;

   typedef struct packed {
      logic [2:0]  kind;
      logic [4:0]  a;
      logic [4:0]  b;
      logic        c;
      logic [31:0] cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   victim_control_if bus();

`ifdef VICTIM_PERF_EN
   logic [15:0] perf_hits, perf_misses, perf_writebacks;
`endif

   victim_control dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef VICTIM_PERF_EN
      ,
      .perf_hits       (perf_hits),
      .perf_misses     (perf_misses),
      .perf_writebacks (perf_writebacks)
`endif
   );

   // Datapath model starts all-valid and dirty so a skipped init sweep shows up.
   lc3b_victim_tag tags [VICTIM_ENTRIES] = '{default: 12'hBEE};
   logic [15:0] dp_valid = 16'hFFFF;
   logic [15:0] dp_dirty = 16'hFFFF;
   always @(posedge clk) begin
      if (bus.write) begin
         tags[bus.idx]     <= bus.mem_address[15:4];
         dp_valid[bus.idx] <= bus.valid_in;
         dp_dirty[bus.idx] <= bus.dirty_in;
      end
   end
   assign bus.tag_data_line = tags;
   assign bus.valid_out     = dp_valid;
   assign bus.dirty_out     = dp_dirty;

   int pmem_delay = 2;
   int held = 0;
   always @(posedge clk) held <= (bus.pmem_read || bus.pmem_write) ? held + 1 : 0;
   assign bus.pmem_resp = (bus.pmem_read || bus.pmem_write) && (held == pmem_delay - 1);

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int compared = 0;
   int mismatched = 0;
   ev_t exp_q [$];

   function automatic string kname(input logic [2:0] k);
      case (k)
         3'd0:    return "write";
         3'd1:    return "mem_resp";
         3'd2:    return "pmem_read_start";
         3'd3:    return "pmem_write_start";
         3'd4:    return "pmem_release";
         default: return "unknown";
      endcase
   endfunction

   function automatic ev_t mk(input int kind, input int a, input int b, input int c, input int when);
      ev_t e;
      e.kind = kind[2:0];
      e.a    = a[4:0];
      e.b    = b[4:0];
      e.c    = c[0];
      e.cyc  = when;
      return e;
   endfunction

   task automatic push(input int kind, input int a, input int b, input int c, input int when);
      exp_q.push_back(mk(kind, a, b, c, when));
   endtask

   task automatic check_ev(input ev_t got);
      ev_t want;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL unexpected_%s: got a=%0d b=%0d c=%0d cyc=%0d, required no event",
                  kname(got.kind), got.a, got.b, got.c, got.cyc);
      end else begin
         want = exp_q.pop_front();
         if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %s a=%0d b=%0d c=%0d cyc=%0d, required %s a=%0d b=%0d c=%0d cyc=%0d",
                     kname(want.kind), kname(got.kind), got.a, got.b, got.c, got.cyc,
                     kname(want.kind), want.a, want.b, want.c, want.cyc);
         end
      end
   endtask

   logic mon_req;
   logic prev_req = 1'b0;
   int   req_len = 0;
   always @(negedge clk) begin
      mon_req = bus.pmem_read | bus.pmem_write;
      if (prev_req && !mon_req) begin
         check_ev(mk(EV_PEND, req_len, 0, 0, cyc));
      end
      if (mon_req && !prev_req) begin
         check_ev(mk(bus.pmem_write ? EV_PWR : EV_PRD, int'(bus.pmem_address_mux_sel),
                     bus.pmem_write ? int'(bus.pmem_wdata_mux_sel) : 0, 0, cyc));
      end
      req_len  = mon_req ? req_len + 1 : 0;
      prev_req = mon_req;
      if (reset_n && bus.write) begin
         check_ev(mk(EV_WR, int'(bus.idx), int'(bus.valid_in), int'(bus.dirty_in), cyc));
      end
      if (bus.mem_resp) begin
         check_ev(mk(EV_RESP, int'(bus.mem_rdata_mux_sel), int'(bus.pmem_read), 0, cyc));
      end
   end

   task automatic issue(input logic wr, input logic [15:0] addr, input logic dirty);
      bus.mem_address = addr;
      bus.mem_dirty   = dirty;
      bus.mem_write   = wr;
      bus.mem_read    = !wr;
   endtask

   task automatic wait_resp(input int limit);
      int n = 0;
      @(negedge clk);
      while (!bus.mem_resp && n < limit) begin
         @(negedge clk);
         n++;
      end
      if (!bus.mem_resp) begin
         compared++;
         mismatched++;
         $display("FAIL resp_timeout: mem_resp=0 after %0d cycles, required 1", limit);
      end
      @(posedge clk);
      #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
   endtask

   task automatic do_insert(input logic [15:0] addr, input logic dirty, input int slot, input int dirty_in);
      push(EV_WR, slot, 1, dirty_in, cyc + 1);
      push(EV_RESP, 0, 0, 0, cyc + 1);
      issue(1'b1, addr, dirty);
      wait_resp(20);
   endtask

   task automatic do_read_hit(input logic [15:0] addr, input int sel);
      push(EV_RESP, sel, 0, 0, cyc + 1);
      issue(1'b0, addr, 1'b0);
      wait_resp(20);
   endtask

   task automatic do_read_miss(input logic [15:0] addr, input int d);
      pmem_delay = d;
      push(EV_PRD, 0, 0, 0, cyc + 1);
      push(EV_RESP, 0, 1, 0, cyc + d);
      push(EV_PEND, d, 0, 0, cyc + d + 1);
      issue(1'b0, addr, 1'b0);
      wait_resp(d + 20);
   endtask

   task automatic do_evict(input logic [15:0] addr, input logic dirty, input int d, input int slot);
      pmem_delay = d;
      push(EV_PWR, slot + 1, slot + 1, 0, cyc + 1);
      push(EV_PEND, d, 0, 0, cyc + d + 1);
      push(EV_WR, slot, 1, int'(dirty), cyc + d + 1);
      push(EV_RESP, 0, 0, 0, cyc + d + 1);
      issue(1'b1, addr, dirty);
      wait_resp(d + 20);
   endtask

   initial begin
      int r;
      int i;
      int n;
      logic [24:0] rst_vec;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.mem_dirty   = 1'b0;
      bus.mem_address = 16'hBEE0;
      reset_n         = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_vec = {bus.write, bus.idx, bus.valid_in, bus.dirty_in, bus.mem_resp, bus.pmem_read,
                 bus.pmem_write, bus.mem_rdata_mux_sel, bus.pmem_address_mux_sel, bus.pmem_wdata_mux_sel};
      compared++;
      if (rst_vec !== {1'b1, 24'd0}) begin
         mismatched++;
         $display("FAIL reset_outputs: got %h, required %h", rst_vec, {1'b1, 24'd0});
      end

      // Init sweep, with a read miss held by L2 throughout it.
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      r = cyc;
      for (int k = 0; k < 16; k++) push(EV_WR, k, 0, 0, r + k);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      pmem_delay = 5;
      push(EV_PRD, 0, 0, 0, r + 17);
      push(EV_RESP, 0, 1, 0, r + 21);
      push(EV_PEND, 5, 0, 0, r + 22);
      issue(1'b0, 16'hBEE0, 1'b0);
      wait_resp(40);

      do_insert(16'h1230, 1'b1, 0, 1);
      do_read_hit(16'h1238, 1);
      do_insert(16'h1230, 1'b0, 0, 1);
      for (int k = 1; k < 16; k++) do_insert({12'h200 + 12'(k), 4'h0}, 1'b1, k, 1);
      do_evict(16'h3000, 1'b1, 3, 0);
      do_evict(16'h3100, 1'b0, 2, 1);
      do_read_hit(16'h2053, 6);
      do_read_miss(16'hBEE0, 2);

      // Reset lands while a writeback to entry 2 is outstanding.
      pmem_delay = 10;
      i = cyc;
      push(EV_PWR, 3, 3, 0, i + 1);
      issue(1'b1, 16'h4000, 1'b1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      bus.mem_write = 1'b0;
      r = cyc;
      push(EV_PEND, 3, 0, 0, r);
      for (int k = 0; k < 16; k++) push(EV_WR, k, 0, 0, r + k);
      reset_n = 1'b1;
      while (cyc < r + 16) begin
         @(posedge clk);
         #1;
      end

      for (int k = 0; k < 16; k++) do_insert({12'h600 + 12'(k), 4'h0}, 1'b1, k, 1);
      do_evict(16'h7000, 1'b0, 2, 0);
      do_read_hit(16'h7008, 1);

      n = 0;
      while (exp_q.size() > 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      while (exp_q.size() > 0) begin
         ev_t e;
         e = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("FAIL missing_%s: got nothing, required a=%0d b=%0d c=%0d cyc=%0d",
                  kname(e.kind), e.a, e.b, e.c, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at time limit, required completion");
      $fatal(1);
   end
endmodule
